mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-port arbiter that shares the single processor-side memory bus between the I-cache and the D-cache. It forwards one command per cycle to memory and returns memory's accept tag to the winning requester in the same cycle. It records which requester owns each outstanding load tag, so returning data is routed to the correct cache. Fixed D-cache priority plus a starvation counter guarantees I-cache forward progress.

## Interface
- STARVE_LIMIT, 4: consecutive contested D-cache wins after which the I-cache gets priority for one grant (1..15).
- MAX_OUTSTANDING, 8: maximum in-flight loads (1..15); further loads are blocked.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ic2arb_addr / ic2arb_command / ic2arb_size  in  `XLEN / BUS_COMMAND / MEM_SIZE  I-cache request; held until accepted
- arb2ic_response  out  4  nonzero = I-cache request accepted this cycle, value is the memory tag
- arb2ic_data / arb2ic_tag  out  `XLEN / 4  returned load data and its tag; tag 0 = nothing returned
- dc2arb_addr / dc2arb_data / dc2arb_command / dc2arb_size  in  `XLEN / `XLEN / BUS_COMMAND / MEM_SIZE  D-cache request; held until accepted
- arb2dc_response / arb2dc_data / arb2dc_tag  out  4 / `XLEN / 4  same as I-cache side
- arb2mem_addr / arb2mem_data / arb2mem_command / arb2mem_size  out  `XLEN / `XLEN / BUS_COMMAND / MEM_SIZE  to memory
- mem2arb_response / mem2arb_data / mem2arb_tag  in  4 / `XLEN / 4  from memory
- outstanding_cnt  out  4  registered count of in-flight loads

## Operation
- A requester is active when its command != BUS_NONE. Loads are blocked while outstanding_cnt == MAX_OUTSTANDING; stores are never blocked.
- Grant, combinational: only one eligible requester -> it wins. Both eligible -> D wins, unless starve_cnt == STARVE_LIMIT, in which case I wins.
- Winner's addr/data/command/size go to memory. I-cache data is forwarded as 0. With no winner: command BUS_NONE, and addr, data, size are 0.
- mem2arb_response goes to the winner's response port only. The loser sees 0.
- starve_cnt (4-bit) updates only on cycles with mem2arb_response != 0:
  - both active and D accepted -> +1, saturating at STARVE_LIMIT
  - I accepted -> cleared
- Tag table: 16 entries of {valid, owner}; entry 0 is never used.
  - Accepted BUS_LOAD with tag t -> valid[t]=1, owner[t]=winner, outstanding_cnt +1.
  - Accepted stores are not recorded.
- Return path: mem2arb_tag = t != 0 with valid[t] -> data and t go to owner's data/tag ports, the other side sees tag 0 and data 0, valid[t] cleared, outstanding_cnt -1.
  - Tag 0, or an unrecorded tag, is dropped: both sides see tag 0.
- Same-cycle allocation and return: counter nets (+1 -1 = 0). If both hit the same t, allocation wins: valid[t] stays 1 with the new owner.
- Reset (rst_n low, at any time):
  - table, starve_cnt and outstanding_cnt cleared
  - responses and tags forced to 0, arb2mem_command forced to BUS_NONE
  - tags returned after reset are dropped

## Timing
- Request -> memory and memory response -> requester: 0 cycles (combinational). Return data -> owner: 0 cycles.
- Table, starve_cnt and outstanding_cnt change at the rising edge after the event.
- Requester keeps its command stable until it sees response != 0; deasserting earlier is legal and costs nothing.
- A rejected grant (response 0) leaves starve_cnt unchanged and the request retries next cycle.
- Reset values: all outputs 0 / BUS_NONE, outstanding_cnt 0.

## Test plan
- Single I-cache load to 0x100, memory responds tag 3, data 0xDEADBEEF returns 5 cycles later with tag 3 -> arb2ic_response=3 in the request cycle, arb2ic_tag=3 and data 0xDEADBEEF on return, arb2dc_tag=0, outstanding 1 then 0.
- Both request continuously, memory accepts every cycle, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- D store and I load contend while memory returns response 0 for 3 cycles -> D stays granted, starve_cnt does not change, accept occurs on cycle 4.
- Issue 8 loads (tags 1..8) with no returns -> 9th load sees response 0 and memory command BUS_NONE, a D store is still forwarded. Return tag 2 -> next load is accepted.
- Tag 5 returns in the same cycle that a new load is accepted with tag 5 by the other cache -> data routed to the old owner, entry 5 re-owned, outstanding unchanged.
- Pull rst_n low with 3 loads outstanding, then return their tags -> all dropped (both tag ports 0), outstanding_cnt 0.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_pkg / mem_bus_arbiter_if
//   Shared bus types and the bundled handshake signals between the I-cache,
//   the D-cache, the arbiter and memory.
//   slave  : arbiter view (requests and memory replies in, grants and returns out)
//   master : environment view (drives requests and memory replies)
package mem_bus_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_t;

  typedef enum logic [1:0] {
    MEM_BYTE   = 2'd0,
    MEM_HALF   = 2'd1,
    MEM_WORD   = 2'd2,
    MEM_DOUBLE = 2'd3
  } mem_size_t;
endpackage

interface mem_bus_arbiter_if;
  import mem_bus_pkg::*;

  // I-cache request / replies
  logic [XLEN-1:0] ic2arb_addr;
  bus_command_t    ic2arb_command;
  mem_size_t       ic2arb_size;
  logic [3:0]      arb2ic_response;
  logic [XLEN-1:0] arb2ic_data;
  logic [3:0]      arb2ic_tag;

  // D-cache request / replies
  logic [XLEN-1:0] dc2arb_addr;
  logic [XLEN-1:0] dc2arb_data;
  bus_command_t    dc2arb_command;
  mem_size_t       dc2arb_size;
  logic [3:0]      arb2dc_response;
  logic [XLEN-1:0] arb2dc_data;
  logic [3:0]      arb2dc_tag;

  // memory side
  logic [XLEN-1:0] arb2mem_addr;
  logic [XLEN-1:0] arb2mem_data;
  bus_command_t    arb2mem_command;
  mem_size_t       arb2mem_size;
  logic [3:0]      mem2arb_response;
  logic [XLEN-1:0] mem2arb_data;
  logic [3:0]      mem2arb_tag;

  modport slave (
    input  ic2arb_addr, ic2arb_command, ic2arb_size,
    input  dc2arb_addr, dc2arb_data, dc2arb_command, dc2arb_size,
    input  mem2arb_response, mem2arb_data, mem2arb_tag,
    output arb2ic_response, arb2ic_data, arb2ic_tag,
    output arb2dc_response, arb2dc_data, arb2dc_tag,
    output arb2mem_addr, arb2mem_data, arb2mem_command, arb2mem_size
  );

  modport master (
    output ic2arb_addr, ic2arb_command, ic2arb_size,
    output dc2arb_addr, dc2arb_data, dc2arb_command, dc2arb_size,
    output mem2arb_response, mem2arb_data, mem2arb_tag,
    input  arb2ic_response, arb2ic_data, arb2ic_tag,
    input  arb2dc_response, arb2dc_data, arb2dc_tag,
    input  arb2mem_addr, arb2mem_data, arb2mem_command, arb2mem_size
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single memory bus between the I-cache and the D-cache. One
//   command per cycle goes to memory; memory's accept tag is handed back to
//   the winner combinationally. Load tags are recorded with their owner so
//   returning data is steered to the right cache. D-cache has fixed priority;
//   a starvation counter hands the I-cache one grant after STARVE_LIMIT
//   consecutive contested D-cache wins.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   bus (slave)       I/D-cache requests and replies, memory command/reply
//   outstanding_cnt   registered count of in-flight loads

// Per-requester slice: eligibility, response gating and return steering.
module mem_bus_arb_port
  import mem_bus_pkg::*;
#(
  parameter logic OWN_ID = 1'b0   // owner id stored in the tag table
) (
  input  bus_command_t    cmd,
  input  logic            full,
  input  logic            gnt,
  input  logic [3:0]      mem_rsp,
  input  logic            ret_hit,
  input  logic            ret_own,
  input  logic [3:0]      ret_tag,
  input  logic [XLEN-1:0] ret_data,
  output logic            elig,
  output logic [3:0]      rsp,
  output logic [3:0]      tag,
  output logic [XLEN-1:0] data
);
  logic mine;

  // loads wait while the tag table is full; stores always go
  assign elig = (cmd != BUS_NONE) && !((cmd == BUS_LOAD) && full);
  assign rsp  = gnt ? mem_rsp : 4'd0;
  assign mine = ret_hit && (ret_own == OWN_ID);
  assign tag  = mine ? ret_tag  : 4'd0;
  assign data = mine ? ret_data : '0;
endmodule

module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT    = 4,  // 1..15
  parameter int unsigned MAX_OUTSTANDING = 8   // 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_bus_arbiter_if.slave bus,
  output logic [3:0]       outstanding_cnt
);
  localparam int NREQ = 2;
  localparam int RI   = 0;   // I-cache slot
  localparam int RD   = 1;   // D-cache slot
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [3:0] OUT_MAX    = 4'(MAX_OUTSTANDING);

  bus_command_t              req_cmd [NREQ];
  logic [NREQ-1:0]           elig, gnt;
  logic [NREQ-1:0][3:0]      port_rsp, port_tag;
  logic [NREQ-1:0][XLEN-1:0] port_data;

  logic [3:0]   starve_cnt;
  logic [15:0]  tbl_vld;     // entry 0 never set: tag 0 means "no tag"
  logic [15:0]  tbl_own;     // 1 = D-cache, 0 = I-cache
  logic         full, accept, alloc, ret_hit, ret_own, ic_act;
  bus_command_t win_cmd;

  assign req_cmd[RI] = bus.ic2arb_command;
  assign req_cmd[RD] = bus.dc2arb_command;
  assign ic_act      = (bus.ic2arb_command != BUS_NONE);

  assign full    = (outstanding_cnt >= OUT_MAX);
  // reset also masks returns so nothing is steered while rst_n is low
  assign ret_hit = rst_n && (bus.mem2arb_tag != 4'd0) && tbl_vld[bus.mem2arb_tag];
  assign ret_own = tbl_own[bus.mem2arb_tag];

  generate
    for (genvar r = 0; r < NREQ; r++) begin : g_port
      mem_bus_arb_port #(.OWN_ID(1'(r))) u_port (
        .cmd      (req_cmd[r]),
        .full     (full),
        .gnt      (gnt[r]),
        .mem_rsp  (bus.mem2arb_response),
        .ret_hit  (ret_hit),
        .ret_own  (ret_own),
        .ret_tag  (bus.mem2arb_tag),
        .ret_data (bus.mem2arb_data),
        .elig     (elig[r]),
        .rsp      (port_rsp[r]),
        .tag      (port_tag[r]),
        .data     (port_data[r])
      );
    end
  endgenerate

  // D wins contention unless the I-cache has been starved long enough.
  assign gnt[RD] = rst_n && elig[RD] && (!elig[RI] || (starve_cnt != STARVE_MAX));
  assign gnt[RI] = rst_n && elig[RI] && !gnt[RD];
  assign accept  = (|gnt) && (bus.mem2arb_response != 4'd0);
  assign alloc   = accept && (win_cmd == BUS_LOAD);

  // memory-side mux; I-cache has no write data
  always_comb begin
    win_cmd          = BUS_NONE;
    bus.arb2mem_addr = '0;
    bus.arb2mem_data = '0;
    bus.arb2mem_size = MEM_BYTE;
    if (gnt[RD]) begin
      win_cmd          = bus.dc2arb_command;
      bus.arb2mem_addr = bus.dc2arb_addr;
      bus.arb2mem_data = bus.dc2arb_data;
      bus.arb2mem_size = bus.dc2arb_size;
    end else if (gnt[RI]) begin
      win_cmd          = bus.ic2arb_command;
      bus.arb2mem_addr = bus.ic2arb_addr;
      bus.arb2mem_size = bus.ic2arb_size;
    end
  end
  assign bus.arb2mem_command = win_cmd;

  assign bus.arb2ic_response = port_rsp[RI];
  assign bus.arb2ic_tag      = port_tag[RI];
  assign bus.arb2ic_data     = port_data[RI];
  assign bus.arb2dc_response = port_rsp[RD];
  assign bus.arb2dc_tag      = port_tag[RD];
  assign bus.arb2dc_data     = port_data[RD];

  // Starvation counter: only accepted grants move it, so memory back-pressure
  // never counts against the I-cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (accept) begin
      if (gnt[RI])
        starve_cnt <= 4'd0;
      else if (ic_act && (starve_cnt < STARVE_MAX))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Tag table. Return clear is written first so a same-tag allocation in the
  // same cycle overrides it and re-owns the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_vld         <= '0;
      tbl_own         <= '0;
      outstanding_cnt <= 4'd0;
    end else begin
      if (ret_hit)
        tbl_vld[bus.mem2arb_tag] <= 1'b0;
      if (alloc) begin
        tbl_vld[bus.mem2arb_response] <= 1'b1;
        tbl_own[bus.mem2arb_response] <= gnt[RD];
      end
      case ({alloc, ret_hit})
        2'b10:   outstanding_cnt <= outstanding_cnt + 4'd1;
        2'b01:   outstanding_cnt <= outstanding_cnt - 4'd1;
        default: outstanding_cnt <= outstanding_cnt;
      endcase
    end
  end
endmodule
